// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and saturating arithmetic for the SNN datapath
package snn_pkg;

  localparam int SNN_WIDTH        = 16;
  localparam int SNN_NUM_INPUTS   = 16;
  localparam int SNN_WEIGHT_WIDTH = 8;

  typedef logic signed [SNN_WIDTH-1:0]        current_t;
  typedef logic signed [SNN_WEIGHT_WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } syn_state_e;

  // Signed add clamped to the current_t range; clip reports that clamping happened.
  function automatic current_t sat_add(input current_t a, input current_t b, output logic clip);
    logic signed [SNN_WIDTH:0] sum;
    current_t                  result;
    sum = {a[SNN_WIDTH-1], a} + {b[SNN_WIDTH-1], b};
    if (sum[SNN_WIDTH] != sum[SNN_WIDTH-1]) begin
      clip   = 1'b1;
      result = sum[SNN_WIDTH] ? {1'b1, {(SNN_WIDTH-1){1'b0}}} : {1'b0, {(SNN_WIDTH-1){1'b1}}};
    end else begin
      clip   = 1'b0;
      result = sum[SNN_WIDTH-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/synapse_integrator_if.sv
// rtl/synapse_integrator_if.sv - spike, weight-write and current-pulse signal bundle
interface synapse_integrator_if #(
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int WEIGHT_WIDTH = 8
);

  logic                           spike_valid;
  logic [ADDR_WIDTH-1:0]          spike_addr;
  logic                           spike_ready;
  logic                           wt_wr_en;
  logic [ADDR_WIDTH-1:0]          wt_wr_addr;
  logic signed [WEIGHT_WIDTH-1:0] wt_wr_data;
  logic                           timestep_tick;
  logic signed [WIDTH-1:0]        input_current;
  logic                           current_valid;
  logic                           sat_flag;
  logic                           tick_overrun;

  modport master (
    output spike_valid, spike_addr, wt_wr_en, wt_wr_addr, wt_wr_data, timestep_tick,
    input  spike_ready, input_current, current_valid, sat_flag, tick_overrun
  );

  modport slave (
    input  spike_valid, spike_addr, wt_wr_en, wt_wr_addr, wt_wr_data, timestep_tick,
    output spike_ready, input_current, current_valid, sat_flag, tick_overrun
  );

endinterface

// File: rtl/synapse_weight_ram.sv
// rtl/synapse_weight_ram.sv - per-synapse weight store, sync read, read-before-write
module synapse_weight_ram #(
  parameter int NUM_INPUTS   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic signed [WEIGHT_WIDTH-1:0] rd_data,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic signed [WEIGHT_WIDTH-1:0] wr_data
);

  logic signed [WEIGHT_WIDTH-1:0] mem [NUM_INPUTS];

  // Registered read sees the pre-write contents; out-of-range addresses read 0 and drop writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (rd_en) begin
        rd_data <= (32'(rd_addr) < NUM_INPUTS) ? mem[rd_addr] : '0;
      end
      if (wr_en && (32'(wr_addr) < NUM_INPUTS)) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/synapse_integrator.sv
// rtl/synapse_integrator.sv - accumulates weighted spikes per timestep for lif_neuron
module synapse_integrator
  import snn_pkg::*;
#(
  parameter int WIDTH        = SNN_WIDTH,
  parameter int NUM_INPUTS   = SNN_NUM_INPUTS,
  parameter int WEIGHT_WIDTH = SNN_WEIGHT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  synapse_integrator_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(NUM_INPUTS);

  syn_state_e                     state;
  logic signed [WIDTH-1:0]        acc;
  logic                           sat_pending;
  logic                           rd_valid;
  logic signed [WEIGHT_WIDTH-1:0] rd_data;
  logic                           spike_accept;
  logic signed [WIDTH-1:0]        w_ext;
  logic signed [WIDTH-1:0]        add_sum;
  logic                           add_clip;
  logic signed [WIDTH-1:0]        current_q;
  logic                           valid_q;
  logic                           sat_q;
  logic                           overrun_q;

  // Spikes are only taken while accumulating and never in the cycle the timestep closes.
  assign bus.spike_ready = (state == ACCUM) && !bus.timestep_tick;
  assign spike_accept    = bus.spike_valid && bus.spike_ready;

  assign bus.input_current = current_q;
  assign bus.current_valid = valid_q;
  assign bus.sat_flag      = sat_q;
  assign bus.tick_overrun  = overrun_q;

  synapse_weight_ram #(
    .NUM_INPUTS   (NUM_INPUTS),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_weight_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (spike_accept),
    .rd_addr (bus.spike_addr),
    .rd_data (rd_data),
    .wr_en   (bus.wt_wr_en),
    .wr_addr (bus.wt_wr_addr),
    .wr_data (bus.wt_wr_data)
  );

  // Second pipeline stage: sign-extend the looked-up weight and add it with saturation.
  always_comb begin
    w_ext    = WIDTH'(rd_data);
    add_clip = 1'b0;
    add_sum  = sat_add(acc, w_ext, add_clip);
  end

  // Marks that rd_data holds a weight that still has to be added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= spike_accept;
    end
  end

  // Timestep FSM: accumulate, let the last add land, then emit a one-cycle current pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      sat_pending <= 1'b0;
      current_q   <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      current_q <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      if (bus.timestep_tick && (state != ACCUM)) begin
        overrun_q <= 1'b1;
      end
      case (state)
        ACCUM, DRAIN: begin
          if (rd_valid) begin
            acc <= add_sum;
            if (add_clip) begin
              sat_pending <= 1'b1;
            end
          end
          if (state == DRAIN) begin
            state <= EMIT;
          end else if (bus.timestep_tick) begin
            state <= DRAIN;
          end
        end
        EMIT: begin
          current_q   <= acc;
          sat_q       <= sat_pending;
          valid_q     <= 1'b1;
          acc         <= '0;
          sat_pending <= 1'b0;
          state       <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_integrator.sv
// tb/tb_synapse_integrator.sv - self-checking bench for synapse_integrator
module tb_synapse_integrator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  synapse_integrator_if #(.WIDTH(16), .ADDR_WIDTH(4), .WEIGHT_WIDTH(8)) bus ();

  synapse_integrator #(.WIDTH(16), .NUM_INPUTS(16), .WEIGHT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: weight table, running timestep sum, closed sum awaiting emission.
  int w_model [16];
  int cur_sum;
  bit cur_sat;
  int pend_sum;
  bit pend_sat;
  int countdown;
  bit ovr_model;
  bit exp_ready;
  bit obs_ready;
  bit exp_valid;
  bit exp_sat;
  int exp_current;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) w_model[i] = 0;
    cur_sum   = 0;
    cur_sat   = 1'b0;
    pend_sum  = 0;
    pend_sat  = 1'b0;
    countdown = 0;
    ovr_model = 1'b0;
  endtask

  task automatic drive_idle();
    bus.spike_valid   = 1'b0;
    bus.spike_addr    = '0;
    bus.wt_wr_en      = 1'b0;
    bus.wt_wr_addr    = '0;
    bus.wt_wr_data    = '0;
    bus.timestep_tick = 1'b0;
  endtask

  // One clock: capture spike_ready, apply the edge to the model, return 1 time unit past the edge.
  task automatic cycle();
    int s;
    #1;
    obs_ready = bus.spike_ready;
    exp_ready = (countdown == 0) && !bus.timestep_tick;
    if (bus.spike_valid && exp_ready) begin
      s = cur_sum + w_model[bus.spike_addr];
      if (s > 32767) begin
        s = 32767;
        cur_sat = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        cur_sat = 1'b1;
      end
      cur_sum = s;
    end
    if (bus.wt_wr_en) w_model[bus.wt_wr_addr] = int'($signed(bus.wt_wr_data));
    exp_valid   = 1'b0;
    exp_current = 0;
    exp_sat     = 1'b0;
    if (countdown > 0) begin
      if (bus.timestep_tick) ovr_model = 1'b1;
      countdown--;
      if (countdown == 0) begin
        exp_valid   = 1'b1;
        exp_current = pend_sum;
        exp_sat     = pend_sat;
      end
    end else if (bus.timestep_tick) begin
      pend_sum  = cur_sum;
      pend_sat  = cur_sat;
      cur_sum   = 0;
      cur_sat   = 1'b0;
      countdown = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input int val);
    bus.wt_wr_en   = 1'b1;
    bus.wt_wr_addr = 4'(addr);
    bus.wt_wr_data = 8'(val);
    cycle();
    bus.wt_wr_en = 1'b0;
  endtask

  task automatic spike(input int addr);
    bus.spike_valid = 1'b1;
    bus.spike_addr  = 4'(addr);
    cycle();
    bus.spike_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.input_current !== 16'sd0) begin errors++; $display("FAIL reset_current got %0d want 0", bus.input_current); end
    checks++; if (bus.current_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.current_valid); end
    checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", bus.sat_flag); end
    checks++; if (bus.tick_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.tick_overrun); end
    checks++; if (bus.spike_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.spike_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    write_w(3, 20);
    write_w(5, -7);
    spike(3);
    spike(5);
    spike(3);
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    checks++; if (bus.current_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", bus.current_valid); end
    cycle();
    checks++; if (bus.current_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.current_valid); end
    checks++; if (bus.input_current !== 16'sd33) begin errors++; $display("FAIL basic_sum got %0d want 33", bus.input_current); end
    checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL basic_sat got %b want 0", bus.sat_flag); end
    cycle();
    checks++; if (bus.current_valid !== 1'b0 || bus.input_current !== 16'sd0) begin errors++; $display("FAIL basic_pulse_end got valid %b current %0d want 0 0", bus.current_valid, bus.input_current); end
  endtask

  task automatic test_saturation();
    write_w(0, 127);
    bus.spike_valid = 1'b1;
    bus.spike_addr  = 4'd0;
    repeat (300) cycle();
    bus.spike_valid   = 1'b0;
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    cycle();
    checks++; if (bus.input_current !== 16'sd32767 || bus.current_valid !== 1'b1) begin errors++; $display("FAIL sat_sum got %0d valid %b want 32767 1", bus.input_current, bus.current_valid); end
    checks++; if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", bus.sat_flag); end
    spike(0);
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    cycle();
    checks++; if (bus.input_current !== 16'sd127 || bus.sat_flag !== 1'b0) begin errors++; $display("FAIL sat_next_step got %0d sat %b want 127 0", bus.input_current, bus.sat_flag); end
  endtask

  task automatic test_tick_stall();
    int accept_at;
    accept_at = -1;
    bus.spike_valid   = 1'b1;
    bus.spike_addr    = 4'd0;
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_with_tick got %b want 0", obs_ready); end
    for (int i = 1; i < 8 && accept_at < 0; i++) begin
      cycle();
      if (obs_ready) accept_at = i;
      if (i == 2) begin
        checks++; if (bus.current_valid !== 1'b1 || bus.input_current !== 16'sd0) begin errors++; $display("FAIL stall_empty_emit got valid %b current %0d want 1 0", bus.current_valid, bus.input_current); end
      end
    end
    bus.spike_valid = 1'b0;
    checks++; if (accept_at != 3) begin errors++; $display("FAIL stall_accept_cycle got %0d want 3", accept_at); end
    cycle();
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    cycle();
    checks++; if (bus.input_current !== 16'sd127 || bus.current_valid !== 1'b1) begin errors++; $display("FAIL stall_next_step got %0d valid %b want 127 1", bus.input_current, bus.current_valid); end
  endtask

  task automatic test_empty_overrun();
    bus.timestep_tick = 1'b1;
    cycle();
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    checks++; if (bus.current_valid !== 1'b1 || bus.input_current !== 16'sd0) begin errors++; $display("FAIL empty_emit got valid %b current %0d want 1 0", bus.current_valid, bus.input_current); end
    checks++; if (bus.tick_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", bus.tick_overrun); end
    cycle();
    checks++; if (bus.current_valid !== 1'b0 || bus.tick_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got valid %b overrun %b want 0 1", bus.current_valid, bus.tick_overrun); end
  endtask

  task automatic test_rbw();
    write_w(2, 4);
    bus.spike_valid = 1'b1;
    bus.spike_addr  = 4'd2;
    bus.wt_wr_en    = 1'b1;
    bus.wt_wr_addr  = 4'd2;
    bus.wt_wr_data  = 8'sd9;
    cycle();
    bus.spike_valid = 1'b0;
    bus.wt_wr_en    = 1'b0;
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    cycle();
    checks++; if (bus.input_current !== 16'sd4) begin errors++; $display("FAIL rbw_old_weight got %0d want 4", bus.input_current); end
    spike(2);
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    cycle();
    checks++; if (bus.input_current !== 16'sd9) begin errors++; $display("FAIL rbw_new_weight got %0d want 9", bus.input_current); end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    write_w(1, 50);
    spike(1);
    spike(1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.input_current !== 16'sd0 || bus.current_valid !== 1'b0 || bus.sat_flag !== 1'b0 || bus.tick_overrun !== 1'b0) begin errors++; $display("FAIL midreset_outputs got current %0d valid %b sat %b overrun %b want all 0", bus.input_current, bus.current_valid, bus.sat_flag, bus.tick_overrun); end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (bus.current_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL midreset_no_emit got valid 1 want 0"); end
    spike(1);
    bus.timestep_tick = 1'b1;
    cycle();
    bus.timestep_tick = 1'b0;
    cycle();
    cycle();
    checks++; if (bus.current_valid !== 1'b1 || bus.input_current !== 16'sd0) begin errors++; $display("FAIL midreset_zero_weight got valid %b current %0d want 1 0", bus.current_valid, bus.input_current); end
  endtask

  task automatic test_random();
    int v;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 700; i++) begin
        case (p)
          0:       v = int'($urandom_range(0, 255)) - 128;
          1:       v = int'($urandom_range(96, 127));
          default: v = -int'($urandom_range(96, 128));
        endcase
        bus.wt_wr_en      = ($urandom_range(0, 9) == 0);
        bus.wt_wr_addr    = 4'($urandom_range(0, 15));
        bus.wt_wr_data    = 8'(v);
        bus.spike_valid   = (p == 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 9);
        bus.spike_addr    = 4'($urandom_range(0, 15));
        bus.timestep_tick = (p == 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 249) == 0);
        cycle();
        checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready p%0d i%0d got %b want %b", p, i, obs_ready, exp_ready); end
        checks++; if (bus.current_valid !== exp_valid) begin errors++; $display("FAIL rand_valid p%0d i%0d got %b want %b", p, i, bus.current_valid, exp_valid); end
        checks++; if (bus.input_current !== 16'(exp_current)) begin errors++; $display("FAIL rand_current p%0d i%0d got %0d want %0d", p, i, bus.input_current, exp_current); end
        checks++; if (bus.sat_flag !== exp_sat) begin errors++; $display("FAIL rand_sat p%0d i%0d got %b want %b", p, i, bus.sat_flag, exp_sat); end
        checks++; if (bus.tick_overrun !== ovr_model) begin errors++; $display("FAIL rand_overrun p%0d i%0d got %b want %b", p, i, bus.tick_overrun, ovr_model); end
      end
    end
    drive_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_tick_stall();
    test_empty_overrun();
    test_rbw();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
